// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers
// returned instructions and hands them to IF/ID over valid/ready.
module if_fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [15:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [15:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] pc_out,
  output logic [15:0] pc2_out,
  output logic [15:0] instr_out
);

  localparam int unsigned   CW       = $clog2(BUF_DEPTH + 1);
  localparam int unsigned   PW       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_L  = (CW + 1)'(BUF_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

  logic [15:0]   fetch_pc;
  logic [15:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] occ;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [15:0]   buf_pc    [BUF_DEPTH];
  logic [15:0]   buf_instr [BUF_DEPTH];

  logic [CW:0]   inflight;
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_nxt;
  logic [15:0]   redirect_aligned;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Credits count both buffered and in-flight entries, so a push never finds the buffer full.
  assign inflight         = {1'b0, occ} + {1'b0, outstanding};
  assign imem_req_valid   = !rst && (inflight < DEPTH_L);
  assign imem_req_addr    = fetch_pc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign rsp_fire         = imem_rsp_valid && (outstanding != '0);
  assign push             = rsp_fire && (drop == '0);
  assign pop              = out_valid && out_ready;
  assign outstanding_nxt  = outstanding + CW'(req_fire) - CW'(rsp_fire);
  assign redirect_aligned = redirect_pc & 16'hFFFE;

  assign out_valid = (occ != '0);
  assign pc_out    = out_valid ? buf_pc[rd_ptr] : '0;
  assign pc2_out   = out_valid ? buf_pc[rd_ptr] + 16'd2 : '0;
  assign instr_out = out_valid ? buf_instr[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      occ         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight, including a request taken this cycle, becomes a drop.
      fetch_pc    <= redirect_aligned;
      rsp_pc      <= redirect_aligned;
      outstanding <= outstanding_nxt;
      drop        <= outstanding_nxt;
      occ         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (req_fire) fetch_pc <= fetch_pc + 16'd2;
      if (rsp_fire && (drop != '0)) drop <= drop - 1'b1;
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        rsp_pc <= rsp_pc + 16'd2;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && push) begin
      buf_pc[wr_ptr]    <= rsp_pc;
      buf_instr[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order memory model with programmable latency,
// two instances (default depth 2 at PC 0000, depth 3 starting at FFFC).
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, mem_ready, out_ready, redir_v, rsp_v;
  logic [15:0] redir_pc, rsp_d;
  int          lat, cyc, vectors, miscompares, w;
  logic [15:0] q_addr [$];
  int          q_due  [$];

  logic        a_req_valid, a_out_valid, b_req_valid, b_out_valid;
  logic [15:0] a_req_addr, a_pc, a_pc2, a_instr;
  logic [15:0] b_req_addr, b_pc, b_pc2, b_instr;
  logic        m_req_valid, m_out_valid;
  logic [15:0] m_req_addr, m_pc, m_pc2, m_instr;

  if_fetch_unit u_dut_a (
    .clk(clk), .rst(rst),
    .redirect_valid(redir_v), .redirect_pc(redir_pc),
    .imem_req_valid(a_req_valid), .imem_req_addr(a_req_addr),
    .imem_req_ready(mem_ready && !sel),
    .imem_rsp_valid(rsp_v && !sel), .imem_rsp_data(rsp_d),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .pc_out(a_pc), .pc2_out(a_pc2), .instr_out(a_instr)
  );

  if_fetch_unit #(.RESET_PC(16'hFFFC), .BUF_DEPTH(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr),
    .imem_req_ready(mem_ready && sel),
    .imem_rsp_valid(rsp_v && sel), .imem_rsp_data(rsp_d),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .pc_out(b_pc), .pc2_out(b_pc2), .instr_out(b_instr)
  );

  assign m_req_valid = sel ? b_req_valid : a_req_valid;
  assign m_req_addr  = sel ? b_req_addr  : a_req_addr;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_pc        = sel ? b_pc        : a_pc;
  assign m_pc2       = sel ? b_pc2       : a_pc2;
  assign m_instr     = sel ? b_instr     : a_instr;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; memory returns addr^A5A5 'lat' cycles after acceptance, in order.
  task automatic step();
    logic        acc;
    logic [15:0] a;
    acc = m_req_valid && mem_ready;
    a   = m_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
    end else if (acc) begin
      q_addr.push_back(a);
      q_due.push_back(cyc + lat - 1);
    end
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      rsp_v = 1'b1;
      rsp_d = q_addr[0] ^ 16'hA5A5;
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      rsp_v = 1'b0;
      rsp_d = 16'h0000;
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] epc, input logic [15:0] epc2,
                            input logic [15:0] einstr, output int waited);
    waited = 0;
    while (!m_out_valid && waited < 20) begin
      step();
      waited++;
    end
    chkb({tag, "_valid"}, m_out_valid, 1'b1);
    chk({tag, "_pc"}, m_pc, epc);
    chk({tag, "_pc2"}, m_pc2, epc2);
    chk({tag, "_instr"}, m_instr, einstr);
    step();
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; mem_ready = 1'b1; out_ready = 1'b1;
    redir_v = 1'b0; redir_pc = 16'h0000; rsp_v = 1'b0; rsp_d = 16'h0000;
    lat = 1; cyc = 0; vectors = 0; miscompares = 0; w = 0;

    step(); step();
    chkb("rst_req_valid", m_req_valid, 1'b0);
    chkb("rst_out_valid", m_out_valid, 1'b0);
    chk("rst_instr", m_instr, 16'h0000);
    chk("rst_pc", m_pc, 16'h0000);
    chk("rst_pc2", m_pc2, 16'h0000);
    rst = 1'b0;
    #1;
    chkb("first_req_valid", m_req_valid, 1'b1);
    chk("first_req_addr", m_req_addr, 16'h0000);

    step();
    chkb("no_bypass", m_out_valid, 1'b0);
    expect_out("s0000", 16'h0000, 16'h0002, 16'hA5A5, w);
    expect_out("s0002", 16'h0002, 16'h0004, 16'hA5A7, w);
    chkw("tput_s0002", w, 0);
    expect_out("s0004", 16'h0004, 16'h0006, 16'hA5A1, w);
    chkw("tput_s0004", w, 1);
    expect_out("s0006", 16'h0006, 16'h0008, 16'hA5A3, w);
    chkw("tput_s0006", w, 0);

    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chkb("bp_valid", m_out_valid, 1'b1);
      chk("bp_pc", m_pc, 16'h0008);
      chk("bp_instr", m_instr, 16'hA5AD);
    end
    chkb("bp_req_valid", m_req_valid, 1'b0);
    out_ready = 1'b1;
    expect_out("bp0008", 16'h0008, 16'h000A, 16'hA5AD, w);
    expect_out("bp000A", 16'h000A, 16'h000C, 16'hA5AF, w);
    expect_out("bp000C", 16'h000C, 16'h000E, 16'hA5A9, w);
    expect_out("bp000E", 16'h000E, 16'h0010, 16'hA5AB, w);

    rst = 1'b1; redir_v = 1'b1; redir_pc = 16'h0100;
    step();
    redir_v = 1'b0;
    step();
    chkb("rst2_req_valid", m_req_valid, 1'b0);
    chkb("rst2_out_valid", m_out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chkb("rst_prio_valid", m_req_valid, 1'b1);
    chk("rst_prio_addr", m_req_addr, 16'h0000);

    mem_ready = 1'b0; rsp_v = 1'b1; rsp_d = 16'hBEEF;
    step();
    chkb("stray_ignored", m_out_valid, 1'b0);
    chkb("stall_valid", m_req_valid, 1'b1);
    chk("stall_addr", m_req_addr, 16'h0000);

    lat = 3; mem_ready = 1'b1;
    step(); step();
    chkb("two_outstanding", m_req_valid, 1'b0);
    redir_v = 1'b1; redir_pc = 16'h0041;
    step();
    redir_v = 1'b0;
    chkb("redir_drop_credit", m_req_valid, 1'b0);
    chkb("redir_cleared", m_out_valid, 1'b0);
    step();
    chkb("redir_req_valid", m_req_valid, 1'b1);
    chk("redir_req_addr", m_req_addr, 16'h0040);
    expect_out("redir0040", 16'h0040, 16'h0042, 16'hA5E5, w);
    expect_out("redir0042", 16'h0042, 16'h0044, 16'hA5E7, w);

    rst = 1'b1; lat = 1;
    step();
    rst = 1'b0; mem_ready = 1'b0; redir_v = 1'b1; redir_pc = 16'h0010;
    step();
    redir_v = 1'b0;
    chk("mstall_addr0", m_req_addr, 16'h0010);
    step();
    chkb("mstall_valid", m_req_valid, 1'b1);
    chk("mstall_addr1", m_req_addr, 16'h0010);
    redir_v = 1'b1; redir_pc = 16'h0100;
    step();
    redir_v = 1'b0;
    chk("mstall_redir_addr", m_req_addr, 16'h0100);
    mem_ready = 1'b1;
    expect_out("mstall0100", 16'h0100, 16'h0102, 16'hA4A5, w);
    expect_out("mstall0102", 16'h0102, 16'h0104, 16'hA4A7, w);

    sel = 1'b1; rst = 1'b1;
    step(); step();
    chkb("b_rst_req_valid", m_req_valid, 1'b0);
    chkb("b_rst_out_valid", m_out_valid, 1'b0);
    chk("b_rst_pc", m_pc, 16'h0000);
    rst = 1'b0;
    #1;
    chk("b_first_addr", m_req_addr, 16'hFFFC);
    expect_out("wFFFC", 16'hFFFC, 16'hFFFE, 16'h5A59, w);
    expect_out("wFFFE", 16'hFFFE, 16'h0000, 16'h5A5B, w);
    chkw("tput_wFFFE", w, 0);
    expect_out("w0000", 16'h0000, 16'h0002, 16'hA5A5, w);
    chkw("tput_w0000", w, 0);
    expect_out("w0002", 16'h0002, 16'h0004, 16'hA5A7, w);
    chkw("tput_w0002", w, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
